// File: rtl/mem_stage_sram_ctrl_if.sv
// mem_stage_sram_ctrl_if: pipeline-side request/response and SRAM-side bus of the MEM-stage controller
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: sequences 32-bit MEM-stage loads/stores as two 16-bit SRAM transfers,
// holding ready low (pipeline freeze) until the access completes.
module mem_stage_sram_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int HALF_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input logic                  clk,
    input logic                  rst,
    mem_stage_sram_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(HALF_CYCLES - 1);

    state_t             state, state_nx;
    logic [3:0]         cnt;
    logic               is_wr;
    logic [SRAM_AW-2:0] widx;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic [15:0]        lo_stage;
    logic               req, last, xfer, oe;

    assign req  = bus.rd_en | bus.wr_en;
    assign last = cnt == LAST;
    assign xfer = state == LO || state == HI;
    assign oe   = xfer && is_wr;

    always_comb begin
        state_nx = state;
        if (state == IDLE && req) state_nx = LO;
        if (state == LO && last) state_nx = HI;
        if (state == HI && last) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    // A simultaneous read+write request is executed as a write
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt      <= '0;
            is_wr    <= 1'b0;
            widx     <= '0;
            wdata    <= '0;
            lo_stage <= '0;
            rdata    <= '0;
        end else if (state == IDLE && req) begin
            cnt   <= '0;
            is_wr <= bus.wr_en;
            widx  <= (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);
            wdata <= bus.write_data;
        end else if (xfer) begin
            cnt <= last ? '0 : cnt + 4'd1;
            if (last && !is_wr && state == LO) lo_stage <= bus.sram_dq_in;
            if (last && !is_wr && state == HI) rdata <= {bus.sram_dq_in, lo_stage};
        end

    // SRAM strobes decode from state only, so request inputs cannot glitch them
    assign bus.ready       = !rst || (state == IDLE && !req) || state == DONE;
    assign bus.sram_addr   = xfer ? {widx, state == HI} : '0;
    assign bus.sram_dq_oe  = oe;
    assign bus.sram_we_n   = !oe;
    assign bus.sram_dq_out = !oe ? 16'h0 : state == HI ? wdata[31:16] : wdata[15:0];
    assign bus.read_data   = rdata;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: random and directed loads/stores checked every cycle against a
// transaction-timeline model with its own reference memory; a second instance runs HALF_CYCLES=1.
module tb_mem_stage_sram_ctrl;
    localparam int H     = 2;
    localparam int LASTK = 2 * H + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_sram_ctrl_if #(.SRAM_AW(18)) b0 ();
    mem_stage_sram_ctrl_if #(.SRAM_AW(18)) b1 ();

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .HALF_CYCLES(H), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .bus(b0)
    );
    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .HALF_CYCLES(1), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    logic [15:0] env     [256];
    logic [15:0] ref_mem [256];

    always_comb b0.sram_dq_in = env[b0.sram_addr[7:0]];
    always_comb b1.sram_dq_in = {8'hA5, b1.sram_addr[7:0]};

    bit          m_act, m_rst, m_wr;
    int          m_k;
    logic [16:0] m_idx;
    logic [31:0] m_wd, exp_rd;
    int          n_vec, n_fail;
    int          low_run, high_run, last_low, last_high;
    bit          c_lo, c_hi, c_oe;
    logic [17:0] c_addr;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (m_rst) begin
            chk("rst_ready", 32'(b0.ready), 32'd1);
            chk("rst_sram_addr", 32'(b0.sram_addr), 32'd0);
            chk("rst_dq_oe", 32'(b0.sram_dq_oe), 32'd0);
            chk("rst_we_n", 32'(b0.sram_we_n), 32'd1);
            chk("rst_dq_out", 32'(b0.sram_dq_out), 32'd0);
            chk("rst_read_data", b0.read_data, 32'd0);
        end else begin
            c_lo   = m_act && m_k >= 1 && m_k <= H;
            c_hi   = m_act && m_k > H && m_k <= 2 * H;
            c_oe   = (c_lo || c_hi) && m_wr;
            c_addr = c_lo ? {m_idx, 1'b0} : c_hi ? {m_idx, 1'b1} : 18'h0;
            chk("ready", 32'(b0.ready), 32'(!m_act || m_k == LASTK));
            chk("sram_addr", 32'(b0.sram_addr), 32'(c_addr));
            chk("dq_oe", 32'(b0.sram_dq_oe), 32'(c_oe));
            chk("we_n", 32'(b0.sram_we_n), 32'(!c_oe));
            if (c_oe) chk("dq_out", 32'(b0.sram_dq_out), 32'(c_lo ? m_wd[15:0] : m_wd[31:16]));
            else if (!(c_lo || c_hi)) chk("dq_out_idle", 32'(b0.sram_dq_out), 32'd0);
            chk("read_data", b0.read_data, exp_rd);
        end
        if (b0.ready) begin
            if (low_run > 0) last_low = low_run;
            low_run = 0;
            high_run++;
        end else begin
            if (high_run > 0) last_high = high_run;
            high_run = 0;
            low_run++;
        end
    end

    task automatic tick();
        if (!b0.sram_we_n) env[b0.sram_addr[7:0]] = b0.sram_dq_out;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        b0.rd_en = 1'b0;
        b0.wr_en = 1'b0;
        b0.address = $urandom;
        b0.write_data = $urandom;
        m_act = 1'b0;
        repeat (n) tick();
    endtask

    task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
        b0.rd_en = rd;
        b0.wr_en = wr;
        b0.address = a;
        b0.write_data = d;
        m_act = 1'b1;
        m_wr  = wr;
        m_idx = 17'((a - 32'd1024) >> 2);
        m_wd  = d;
        for (int k = 0; k <= LASTK; k++) begin
            m_k = k;
            if (k == LASTK) begin
                if (wr) begin
                    ref_mem[{m_idx[6:0], 1'b0}] = d[15:0];
                    ref_mem[{m_idx[6:0], 1'b1}] = d[31:16];
                end else exp_rd = {ref_mem[{m_idx[6:0], 1'b1}], ref_mem[{m_idx[6:0], 1'b0}]};
            end
            tick();
        end
    endtask

    // Reset lands in the first HI cycle, before any HI half-word can be strobed
    task automatic reset_mid_store(logic [31:0] a, logic [31:0] d);
        logic [7:0] lo_a, hi_a;
        b0.rd_en = 1'b0;
        b0.wr_en = 1'b1;
        b0.address = a;
        b0.write_data = d;
        m_act = 1'b1;
        m_wr  = 1'b1;
        m_idx = 17'((a - 32'd1024) >> 2);
        m_wd  = d;
        for (int k = 0; k <= H; k++) begin
            m_k = k;
            tick();
        end
        lo_a = {m_idx[6:0], 1'b0};
        hi_a = {m_idx[6:0], 1'b1};
        rst = 1'b0;
        m_rst = 1'b1;
        m_act = 1'b0;
        exp_rd = 32'd0;
        #1;
        chk("midrst_we_n", 32'(b0.sram_we_n), 32'd1);
        chk("midrst_dq_oe", 32'(b0.sram_dq_oe), 32'd0);
        chk("midrst_ready", 32'(b0.ready), 32'd1);
        b0.wr_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_rst = 1'b0;
        ref_mem[lo_a] = d[15:0];
        chk("midrst_hi_not_written", 32'(env[hi_a]), 32'(ref_mem[hi_a]));
        chk("midrst_lo_written", 32'(env[lo_a]), 32'(d[15:0]));
        tick();
    endtask

    task automatic h1_access(bit rd, bit wr, logic [31:0] a, logic [31:0] d, logic [31:0] exp_data);
        int n = 0;
        b1.rd_en = rd;
        b1.wr_en = wr;
        b1.address = a;
        b1.write_data = d;
        #1;
        while (!b1.ready && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("h1_ready_low_cycles", 32'(n), 32'd3);
        chk("h1_read_data", b1.read_data, exp_data);
        b1.rd_en = 1'b0;
        b1.wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int op, gap;
        logic [31:0] a;
        b0.rd_en = 1'b0;
        b0.wr_en = 1'b0;
        b0.address = '0;
        b0.write_data = '0;
        b1.rd_en = 1'b0;
        b1.wr_en = 1'b0;
        b1.address = '0;
        b1.write_data = '0;
        m_rst = 1'b1;
        m_act = 1'b0;
        exp_rd = '0;
        for (int i = 0; i < 256; i++) begin
            env[i] = 16'($urandom);
            ref_mem[i] = env[i];
        end
        env[10] = 16'h5678;
        env[11] = 16'h1234;
        ref_mem[10] = 16'h5678;
        ref_mem[11] = 16'h1234;
        repeat (3) begin
            b0.rd_en = 1'($urandom);
            b0.wr_en = 1'($urandom);
            b0.address = $urandom;
            b0.write_data = $urandom;
            @(posedge clk);
            #1;
        end
        idle(0);
        rst = 1'b1;
        m_rst = 1'b0;
        tick();

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        idle(1);
        chk("store_ready_low", 32'(last_low), 32'd5);
        chk("store_lo_half", 32'(env[0]), 32'h0000BEEF);
        chk("store_hi_half", 32'(env[1]), 32'h0000DEAD);

        access(1'b1, 1'b0, 32'd1044, 32'd0);
        chk("load_done_data", b0.read_data, 32'h12345678);
        idle(2);
        chk("load_held_data", b0.read_data, 32'h12345678);

        access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D);
        idle(1);
        chk("both_lo_half", 32'(env[2]), 32'h0000F00D);
        chk("both_hi_half", 32'(env[3]), 32'h0000CAFE);
        chk("both_read_data_kept", b0.read_data, 32'h12345678);

        access(1'b0, 1'b1, 32'd1100, 32'h0BADC0DE);
        access(1'b1, 1'b0, 32'd1100, 32'd0);
        chk("b2b_load_data", b0.read_data, 32'h0BADC0DE);
        chk("b2b_ready_gap", 32'(last_high), 32'd1);
        chk("b2b_ready_low", 32'(last_low), 32'd5);
        idle(1);

        repeat (60) begin
            op = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0) ? $urandom
                : 32'd1024 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            access(op != 1, op != 0, a, $urandom);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
        end
        idle(2);

        reset_mid_store(32'd1056, $urandom);
        idle(2);
        access(1'b1, 1'b0, 32'd1056, 32'd0);
        idle(1);

        h1_access(1'b0, 1'b1, 32'd1024, 32'h11112222, 32'd0);
        h1_access(1'b1, 1'b0, 32'd1044, 32'd0, 32'hA50BA50A);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Sequences every MEM-stage access from the EXE/MEM pipeline register onto a 16-bit-wide external SRAM; each 32-bit word takes two half-word transfers.
- Drives `ready` low while an access is in progress; the pipeline uses `~ready` as the global freeze for PC, stage registers and the EXE/MEM register.
- Sits between the EXE/MEM register outputs (`mem_read`, `mem_write`, ALU result as address, `val_Rm` as store data) and the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- HALF_CYCLES, 2: cycles each half-word transfer is held on the SRAM bus; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request (the `mem_read` output of the EXE/MEM register).
- wr_en  in  1  store request (the `mem_write` output of the EXE/MEM register).
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store data (`val_Rm`).
- read_data  out  32  load result; held until the next load completes.
- ready  out  1  high = no access pending or access completing this cycle; freeze = ~ready.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  write data to the SRAM.
- sram_dq_oe  out  1  high = controller drives the data bus.
- sram_dq_in  in  16  read data from the SRAM.
- sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- Reset (rst=0, takes effect immediately with no clock edge):
  - state=IDLE, counter=0, captured op/address/data=0.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address map: word_idx = (address - BASE_ADDR)[SRAM_AW:2], computed modulo 2^32. No range check; out-of-range addresses wrap. address[1:0] is ignored.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en|wr_en is high, capture op, word_idx and write_data, clear the counter, and go to LO.
  - If both are high, perform a write.
  - Otherwise stay in IDLE.
- LO:
  - sram_addr={word_idx,0}.
  - Write: sram_dq_out=wdata[15:0], sram_dq_oe=1, sram_we_n=0.
  - Read: sram_dq_oe=0, sram_we_n=1.
  - The counter increments each cycle. On counter==HALF_CYCLES-1: for a read, latch sram_dq_in into the low-half staging register; clear the counter; go to HI.
- HI:
  - Same as LO with sram_addr={word_idx,1} and bits [31:16].
  - On the final cycle for a read, read_data <= {sram_dq_in, low staging} at the clock edge.
  - Go to DONE.
- DONE:
  - SRAM bus idle (we_n=1, oe=0); go to IDLE.
  - rd_en/wr_en are ignored, because the frozen EXE/MEM register still presents the completed request.
- ready (combinational): 1 when (state==IDLE && !rd_en && !wr_en) or state==DONE; 0 otherwise. It therefore drops in the same cycle a request appears.
- Latency: request seen in IDLE at cycle T0 gives DONE at T0+2*HALF_CYCLES+1.
  - ready is low for 2*HALF_CYCLES+1 cycles (5 at the default).
  - Load data is valid on read_data from the DONE cycle onward.
- sram_addr, sram_dq_out, sram_dq_oe and sram_we_n are registered or decoded from state only; no glitching from request inputs.
- sram_addr and sram_dq_out are 0 in IDLE and DONE.
- Back-to-back accesses: a new request in the cycle after DONE starts immediately, with one ready=1 cycle (DONE) between accesses.
- Reset asserted mid-access abandons the transfer: sram_we_n rises and sram_dq_oe falls asynchronously, and the partial write is not completed.
- read_data is not modified by writes.

Test Plan:
- Reset: hold rst=0 with random inputs -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0. Release rst -> state IDLE.
- Store: wr_en=1, address=1024, write_data=0xDEADBEEF held while ready=0:
  - sram_addr=0 with dq_out=0xBEEF and we_n=0 for 2 cycles, then sram_addr=1 with dq_out=0xDEAD for 2 cycles.
  - ready low exactly 5 cycles, then high 1 cycle.
- Load: SRAM model preloaded with half-words 10=0x5678 and 11=0x1234; rd_en=1, address=1044 -> sram_addr 10 then 11, we_n=1 throughout, read_data=0x12345678 in the DONE cycle and held afterwards.
- Both rd_en and wr_en high, address=1028, data=0xCAFEF00D -> write executed: SRAM half-words 2=0xF00D and 3=0xCAFE; read_data unchanged.
- Back-to-back: store then load to the same address, requests re-asserted the cycle after DONE -> load returns the stored word; exactly one ready=1 cycle between the two accesses.
- rst pulsed low during HI of a store -> we_n=1 and dq_oe=0 before the next edge, the HI half is not written, and ready=1.
- Build with HALF_CYCLES=1 -> ready low 3 cycles per access.
